// File: rtl/wb_timeout_bridge.sv
// rtl/wb_timeout_bridge.sv - single-outstanding Wishbone pipelined bridge with response timeout
//
// Takes one upstream request, registers it and issues it downstream. It then
// waits for ack/err. If neither arrives within TIMEOUT cycles of the first
// downstream strobe, the bridge answers upstream with an error.
//
// Parameters
//   TIMEOUT      maximum cycles from downstream strobe to ack/err; 0 disables the timeout
//
// Optional feature
//   WB_ERR_LOG_EN  when defined, adds err_adr_o/err_valid_o. These hold the address
//                  of the first error or timeout and stay set until reset.
//
// Ports
//   wb_clk_i, wb_rst_i                      clock (rising edge), async active-high reset
//   s_cyc_i, s_stb_i, s_we_i                upstream request strobes
//   s_adr_i, s_dat_i, s_sel_i               upstream address / write data / byte selects
//   s_stall_o, s_ack_o, s_err_o, s_dat_o    upstream stall, response pulses, read data
//   m_cyc_o, m_stb_o, m_we_o                downstream request strobes
//   m_adr_o, m_dat_o, m_sel_o               registered copy of the accepted request
//   m_stall_i, m_ack_i, m_err_i, m_dat_i    downstream stall, responses, read data
//   timeout_o                               one-cycle pulse when a transaction times out
//   err_adr_o, err_valid_o                  first-error log (WB_ERR_LOG_EN only)

module wb_timeout_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic [3:0]  s_sel_i,
  output logic        s_stall_o,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic [31:0] s_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic        m_stall_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic [31:0] m_dat_i,
  output logic        timeout_o
`ifdef WB_ERR_LOG_EN
  ,
  output logic [31:0] err_adr_o,
  output logic        err_valid_o
`endif
);

  // A zero TIMEOUT still needs a legal (1-bit) counter; it is simply never compared.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic busy;
  logic resp_ok;
  logic tmo_hit;
  logic rsp_err;
  logic rsp_ack;
  logic rsp_tmo;
  logic done;

  // Responses count in WAIT. In ISSUE they count only on the cycle the strobe is
  // actually accepted (stall low). Abort beats every response. Err beats ack.
  // A real response beats a timeout that falls on the same cycle.
  always_comb begin
    busy    = (state == S_ISSUE) || (state == S_WAIT);
    resp_ok = (state == S_WAIT) || ((state == S_ISSUE) && !m_stall_i);
    tmo_hit = (TIMEOUT != 0) && (cnt == TMO);
    rsp_err = busy && s_cyc_i && resp_ok && m_err_i;
    rsp_ack = busy && s_cyc_i && resp_ok && m_ack_i && !m_err_i;
    rsp_tmo = busy && s_cyc_i && !(resp_ok && (m_ack_i || m_err_i)) && tmo_hit;
    done    = busy && (!s_cyc_i || rsp_err || rsp_ack || rsp_tmo);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      s_stall_o <= 1'b0;
      s_ack_o   <= 1'b0;
      s_err_o   <= 1'b0;
      s_dat_o   <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_sel_o   <= '0;
      timeout_o <= 1'b0;
    end else begin
      s_ack_o   <= 1'b0;
      s_err_o   <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (s_cyc_i && s_stb_i) begin
            m_we_o    <= s_we_i;
            m_adr_o   <= s_adr_i;
            m_dat_o   <= s_dat_i;
            m_sel_o   <= s_sel_i;
            cnt       <= '0;
            m_cyc_o   <= 1'b1;
            m_stb_o   <= 1'b1;
            s_stall_o <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (done) begin
            // An abort (s_cyc_i low) lands here with all three response flags clear,
            // so the upstream side sees nothing.
            state     <= S_IDLE;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            s_stall_o <= 1'b0;
            s_ack_o   <= rsp_ack;
            s_err_o   <= rsp_err || rsp_tmo;
            timeout_o <= rsp_tmo;
            if (rsp_ack) begin
              s_dat_o <= m_dat_i;
            end
          end else if ((state == S_ISSUE) && !m_stall_i) begin
            state   <= S_WAIT;
            m_stb_o <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          m_cyc_o   <= 1'b0;
          m_stb_o   <= 1'b0;
          s_stall_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_ERR_LOG_EN
  // Only the first failing address is kept. Later errors leave it untouched.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_adr_o   <= '0;
      err_valid_o <= 1'b0;
    end else if ((rsp_err || rsp_tmo) && !err_valid_o) begin
      err_adr_o   <= m_adr_o;
      err_valid_o <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/wb_timeout_bridge.md
WB_TIMEOUT_BRIDGE -- requirements
Module: wb_timeout_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles from downstream strobe to ack/err; 0 disables timeout.
REQ-002 SHALL have port wb_clk_i  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports s_cyc_i, s_stb_i, s_we_i  in  1 each  upstream (core-side) Wishbone pipelined request.
REQ-005 SHALL have ports s_adr_i, s_dat_i, s_sel_i  in  32/32/4  upstream address, write data, byte selects.
REQ-006 SHALL have ports s_stall_o, s_ack_o, s_err_o  out  1 each  upstream stall, ack, error.
REQ-007 SHALL have port s_dat_o  out  32  upstream read data.
REQ-008 SHALL have ports m_cyc_o, m_stb_o, m_we_o  out  1 each  downstream (peripheral-side) request.
REQ-009 SHALL have ports m_adr_o, m_dat_o, m_sel_o  out  32/32/4  registered copies of the accepted request.
REQ-010 SHALL have ports m_stall_i, m_ack_i, m_err_i  in  1 each  downstream stall, ack, error.
REQ-011 SHALL have port m_dat_i  in  32  downstream read data.
REQ-012 SHALL have port timeout_o  out  1  one-cycle pulse on timeout.

Function
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-014 IDLE: s_stall_o=0; on s_cyc_i&s_stb_i SHALL register we/adr/dat/sel, clear counter, go ISSUE.
REQ-015 ISSUE: m_cyc_o=1, m_stb_o=1; on edge with m_stall_i=0 SHALL go WAIT (m_stb_o=0 next cycle).
REQ-016 WAIT: m_cyc_o=1, m_stb_o=0 until response or timeout.
REQ-017 s_stall_o SHALL be 1 in ISSUE and WAIT.
REQ-018 m_ack_i in ISSUE/WAIT (ISSUE only when m_stall_i=0) SHALL give s_ack_o=1 one cycle later for one cycle, s_dat_o=m_dat_i captured, next state IDLE.
REQ-019 m_err_i SHALL give s_err_o one-cycle pulse, same timing as ack; err wins if ack and err coincide.
REQ-020 Counter SHALL increment each cycle in ISSUE/WAIT, width $clog2(TIMEOUT+1), saturating.
REQ-021 Counter==TIMEOUT with no ack/err that cycle (TIMEOUT!=0) SHALL pulse s_err_o and timeout_o next cycle, drop m_cyc_o/m_stb_o, go IDLE.
REQ-022 Ack/err arriving same cycle as timeout SHALL be honoured as ack/err; timeout_o stays 0.
REQ-023 s_cyc_i low in ISSUE/WAIT SHALL abort: m_cyc_o/m_stb_o low next cycle, no s_ack_o/s_err_o, IDLE; late m_ack_i ignored.
REQ-024 Latency: request edge to m_stb_o=1 is 1 cycle; m_ack_i to s_ack_o is 1 cycle; zero-wait slave gives s_ack_o 3 cycles after request.
REQ-025 s_dat_o SHALL hold last captured value; updated only on ack.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, and all outputs 0 (s_stall_o, s_ack_o, s_err_o, s_dat_o, m_*_o, timeout_o).
REQ-027 Reset mid-transaction SHALL drop m_cyc_o immediately (asynchronously), produce no response.

Configuration
REQ-028 Macro WB_ERR_LOG_EN defined SHALL add outputs err_adr_o (32) and err_valid_o (1): first error/timeout latches its m_adr_o, sets err_valid_o sticky; later errors ignored; cleared only by reset.
REQ-029 Macro WB_ERR_LOG_EN undefined SHALL omit both ports and logic; all other behaviour identical.

Verification
REQ-030 Write adr 0x2000_0000 dat 0x1, slave acks 1 cycle after m_stb_o -> m_adr_o/m_dat_o match, s_ack_o pulse 3 cycles after request, timeout_o 0.
REQ-031 Read, m_stall_i high 4 cycles, then ack with m_dat_i 0xDEAD_BEEF -> m_stb_o high 5 cycles, s_dat_o=0xDEAD_BEEF with s_ack_o.
REQ-032 TIMEOUT=8, slave silent -> s_err_o and timeout_o pulse once, m_cyc_o low; with WB_ERR_LOG_EN err_adr_o=request address, err_valid_o=1.
REQ-033 m_ack_i and m_err_i same cycle -> only s_err_o pulses; ack on timeout cycle -> s_ack_o, no timeout_o.
REQ-034 s_cyc_i dropped in WAIT, then late m_ack_i -> no s_ack_o, next request accepted normally.
REQ-035 wb_rst_i asserted in WAIT -> all outputs 0 immediately; post-reset transaction completes normally.
